data_memory_ctl: RTL and testbench
==================================

Name: data_memory_ctl

Overview:
- Parametrised successor to the CPU's 16-bit data RAM.
- Single-port synchronous data memory with a valid/ready request interface and separate write and read commands.
- Configurable read latency (1-3 cycles), out-of-range address detection, and a hardware clear sequencer that zeroes every word after reset.
- Sits between the load/store stage of the core and the memory array; replaces the simulation-only initial clear.

Parameters:
- DATA_W, 16, data word width in bits.
- ADDR_W, 10, address width in bits.
- DEPTH, 1024, number of words; must satisfy 1 <= DEPTH <= 2**ADDR_W.
- RD_LAT, 1, read latency in cycles from request accept to rsp_valid; legal values 1..3.

Ports:
- clock  input  1  system clock, rising-edge.
- reset_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present this cycle.
- req_ready  output  1  block can accept a request this cycle.
- req_write  input  1  1 = write, 0 = read; sampled on accept.
- req_addr  input  ADDR_W  word address.
- req_wdata  input  DATA_W  write data.
- rsp_valid  output  1  read data valid; one-cycle pulse per accepted read.
- rsp_rdata  output  DATA_W  read data; held between pulses.
- rsp_err  output  1  accepted read addressed >= DEPTH; aligned with rsp_valid.
- wr_err  output  1  one-cycle pulse the cycle after an accepted out-of-range write.
- busy  output  1  clear sequencer active.

Behaviour:
- Reset asserted, asynchronously:
  - req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, wr_err=0, busy=1.
  - Clear counter=0; state=INIT; read pipeline flushed.
- State INIT:
  - Each cycle writes 0 to mem[cnt], then cnt++.
  - After writing DEPTH-1, next state is RUN. INIT lasts exactly DEPTH cycles after reset_n rises.
  - busy=1, req_ready=0. Requests are ignored and never queued.
- State RUN:
  - busy=0, req_ready=1 every cycle; no back-pressure.
  - Accept = req_valid & req_ready.
- Write accept, in range:
  - mem[req_addr] <= req_wdata at that edge.
  - No response.
- Write accept, out of range (addr >= DEPTH):
  - Memory unchanged.
  - wr_err=1 for the following cycle.
- Read accept:
  - rsp_valid=1 exactly RD_LAT cycles after the accept edge, for one cycle.
  - rsp_rdata = word at req_addr as of the accept edge.
  - Out-of-range read: rsp_rdata=0 and rsp_err=1 with that same pulse.
- Back-to-back reads, one per cycle: responses emerge in order, one per cycle, each RD_LAT later.
  - Pipeline is a RD_LAT-deep shift register of {valid, err, data}.
  - Array read registered at stage 1; later stages are pure delay.
- Read-after-write:
  - A read accepted the cycle after a write to the same address returns the new data.
  - Only one request exists per cycle, so there is no same-cycle conflict.
- rsp_rdata holds its last value when rsp_valid=0. rsp_err=0 whenever rsp_valid=0.
- Reset mid-operation (in INIT or RUN):
  - Immediate return to reset values.
  - In-flight reads are discarded: no rsp_valid.
  - Memory is fully re-zeroed by a new INIT pass.
- Addresses are never wrapped or truncated; all of the top bits are compared against DEPTH.
- DEPTH==2**ADDR_W: out-of-range is impossible and the err outputs stay 0.

Decomposition:
- Shared package dmem_pkg:
  - State enum {INIT, RUN}.
  - Constant RD_LAT_MAX=3.
  - Function range_ok(addr, depth).
- Sub-module dmem_array:
  - Plain synchronous single-port RAM with one write port and a registered read port, parameterised by DATA_W, ADDR_W, DEPTH.
  - Controller instantiates it and muxes the clear writes ahead of core writes.
- Elaboration check: RD_LAT outside 1..3, or DEPTH > 2**ADDR_W, is an error.

Test Plan:
- Reset release, DEPTH=8 -> busy=1 and req_ready=0 for exactly 8 cycles, then busy=0 and req_ready=1; reads of addr 0..7 return 0x0000.
- RUN, RD_LAT=1: write 0xBEEF to addr 5, read addr 5 next cycle -> rsp_valid one cycle later with rsp_rdata=0xBEEF, rsp_err=0.
- RD_LAT=3: reads of addr 1, 2, 3 on consecutive cycles, preloaded with 0x0011/0x0022/0x0033 -> rsp_valid high for 3 consecutive cycles starting 3 cycles after the first accept, data in that order.
- DEPTH=6, ADDR_W=3:
  - Read addr 7 -> rsp_valid with rsp_rdata=0, rsp_err=1.
  - Write 0x1234 to addr 6 -> wr_err pulse; a later read of addr 6 gives rsp_err=1 and data 0.
- req_valid held high during INIT with a write of 0xAAAA to addr 2 -> ignored; after INIT, read addr 2 returns 0x0000.
- Write 0x5A5A to addr 4, issue a read, then assert reset_n=0 before rsp_valid -> no rsp_valid; after re-INIT, read addr 4 returns 0x0000.

Source files
------------

// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data memory controller: controller state
// encoding, the maximum supported read latency and the address range test.
// -----------------------------------------------------------------------------
package dmem_pkg;

    // Controller state: INIT zeroes the array word by word, RUN serves requests.
    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Deepest read pipeline the controller supports.
    localparam int unsigned RD_LAT_MAX = 3;

    // True when a word address falls inside the populated part of the array.
    // The full address is compared, so out-of-range addresses never alias.
    function automatic logic range_ok(input logic [31:0] addr, input logic [31:0] depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// -----------------------------------------------------------------------------
// dmem_array
// Plain single-port synchronous RAM: one write port and a registered read
// port sharing one address. Write and read are never requested together.
//
// Ports:
//   clock    in   rising-edge clock
//   reset_n  in   async active-low reset (read register only)
//   we_i     in   write enable
//   re_i     in   read enable; loads rdata_o at the edge
//   addr_i   in   word address (always < DEPTH when enabled)
//   wdata_i  in   write data
//   rdata_o  out  registered read data, held while re_i is low
// -----------------------------------------------------------------------------
module dmem_array #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DEPTH  = 1024
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // NOTE: the storage array has no reset; resetting it would turn RAM into
    // flops. The controller's clear sequencer zeroes it after every reset.
    always_ff @(posedge clock) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // The read register is an ordinary flop, so it starts from zero.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_memory_ctl.sv
// -----------------------------------------------------------------------------
// data_memory_ctl
// Data memory controller for the load/store stage. After reset it zeroes the
// whole array (INIT, busy=1), then accepts one read or write per cycle with no
// back-pressure. Reads return RD_LAT cycles after accept through a shift
// register of {valid, err, data}; out-of-range accesses are flagged.
//
// Ports:
//   clock      in   rising-edge clock
//   reset_n    in   async active-low reset
//   req_valid  in   request present
//   req_ready  out  request accepted this cycle (RUN state)
//   req_write  in   1 = write, 0 = read
//   req_addr   in   word address (full width checked against DEPTH)
//   req_wdata  in   write data
//   rsp_valid  out  one-cycle pulse per accepted read
//   rsp_rdata  out  read data, held between pulses
//   rsp_err    out  read was out of range (only with rsp_valid)
//   wr_err     out  pulse the cycle after an out-of-range write
//   busy       out  clear sequencer active
// -----------------------------------------------------------------------------
module data_memory_ctl
    import dmem_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DEPTH  = 1024,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              wr_err,
    output logic              busy
);

    if (RD_LAT < 1 || RD_LAT > RD_LAT_MAX || DEPTH < 1 || ADDR_W < 1 || ADDR_W > 31 ||
        64'(DEPTH) > (64'd1 << ADDR_W)) begin : g_bad_param
        $error("data_memory_ctl: illegal parameters RD_LAT=%0d DEPTH=%0d ADDR_W=%0d",
               RD_LAT, DEPTH, ADDR_W);
    end

    // Array index width: only enough bits to address DEPTH words. The upper
    // request bits take part in the range check and are never used to index.
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  cnt_q, cnt_d;

    logic              in_range;
    logic              accept;
    logic              wr_acc;
    logic              rd_acc;

    logic              arr_we;
    logic              arr_re;
    logic [IDX_W-1:0]  arr_addr;
    logic [DATA_W-1:0] arr_wdata;
    logic [DATA_W-1:0] arr_rdata;

    logic [RD_LAT-1:0] valid_q;
    logic [RD_LAT-1:0] err_q;
    logic              oor_q;
    logic              wr_err_q;
    logic [DATA_W-1:0] s0_data;

    // ---------------- FSM: state register ----------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ---------------- FSM: next state ----------------
    // NOTE: defaults first, so no path through the case leaves a signal
    // unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            INIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == IDX_W'(DEPTH - 1)) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN:     state_d = RUN;
            default: state_d = INIT;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy      = 1'b1;
        req_ready = 1'b0;
        if (state_q == RUN) begin
            busy      = 1'b0;
            req_ready = 1'b1;
        end
    end

    // ---------------- request decode ----------------
    assign in_range = range_ok(32'(req_addr), DEPTH);
    assign accept   = req_valid & req_ready;
    assign wr_acc   = accept & req_write;
    assign rd_acc   = accept & ~req_write;

    // Clear writes take the port during INIT; no request is accepted then.
    assign arr_we    = (state_q == INIT) | (wr_acc & in_range);
    assign arr_re    = rd_acc & in_range;
    assign arr_addr  = (state_q == INIT) ? cnt_q : req_addr[IDX_W-1:0];
    assign arr_wdata = (state_q == INIT) ? '0 : req_wdata;

    dmem_array #(
        .DATA_W (DATA_W),
        .ADDR_W (IDX_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clock   (clock),
        .reset_n (reset_n),
        .we_i    (arr_we),
        .re_i    (arr_re),
        .addr_i  (arr_addr),
        .wdata_i (arr_wdata),
        .rdata_o (arr_rdata)
    );

    // ---------------- read pipeline control ----------------
    // oor_q changes only on a read accept, like the array read register, so
    // stage-1 data stays stable between reads and out-of-range reads show 0.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q  <= '0;
            err_q    <= '0;
            oor_q    <= 1'b0;
            wr_err_q <= 1'b0;
        end else begin
            valid_q[0] <= rd_acc;
            err_q[0]   <= rd_acc & ~in_range;
            for (int k = 1; k < RD_LAT; k++) begin
                valid_q[k] <= valid_q[k-1];
                err_q[k]   <= err_q[k-1];
            end
            if (rd_acc) begin
                oor_q <= ~in_range;
            end
            wr_err_q <= wr_acc & ~in_range;
        end
    end

    assign s0_data = oor_q ? '0 : arr_rdata;

    // Stages after the array register are pure delay; each loads only when a
    // response moves into it, so the output holds between pulses.
    if (RD_LAT == 1) begin : g_lat1
        assign rsp_rdata = s0_data;
    end else begin : g_latn
        logic [DATA_W-1:0] dly_q [RD_LAT-1];

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                for (int k = 0; k < RD_LAT - 1; k++) begin
                    dly_q[k] <= '0;
                end
            end else begin
                if (valid_q[0]) begin
                    dly_q[0] <= s0_data;
                end
                for (int k = 1; k < RD_LAT - 1; k++) begin
                    if (valid_q[k]) begin
                        dly_q[k] <= dly_q[k-1];
                    end
                end
            end
        end

        assign rsp_rdata = dly_q[RD_LAT-2];
    end

    assign rsp_valid = valid_q[RD_LAT-1];
    assign rsp_err   = err_q[RD_LAT-1];
    assign wr_err    = wr_err_q;

endmodule

// File: tb/tb_data_memory_ctl.sv
// -----------------------------------------------------------------------------
// tb_data_memory_ctl
// Three controller instances sharing clock and reset:
//   0: ADDR_W=4, DEPTH=8, RD_LAT=1  (out-of-range via upper address bits)
//   1: ADDR_W=3, DEPTH=8, RD_LAT=3  (full depth, err never set)
//   2: ADDR_W=3, DEPTH=6, RD_LAT=2  (partial depth)
// Inputs change #1 after a rising edge; outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_data_memory_ctl;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic            reset_n;
    logic [2:0]      req_valid, req_write, req_ready;
    logic [2:0]      rsp_valid, rsp_err, wr_err, busy;
    logic [2:0][3:0] req_addr;
    logic [2:0][15:0] req_wdata, rsp_rdata;

    int n_vec = 0;
    int n_err = 0;

    data_memory_ctl #(.DATA_W(16), .ADDR_W(4), .DEPTH(8), .RD_LAT(1)) u_a (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]),
        .wr_err(wr_err[0]), .busy(busy[0])
    );

    data_memory_ctl #(.DATA_W(16), .ADDR_W(3), .DEPTH(8), .RD_LAT(3)) u_b (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
        .req_addr(req_addr[1][2:0]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]),
        .wr_err(wr_err[1]), .busy(busy[1])
    );

    data_memory_ctl #(.DATA_W(16), .ADDR_W(3), .DEPTH(6), .RD_LAT(2)) u_c (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_write(req_write[2]),
        .req_addr(req_addr[2][2:0]), .req_wdata(req_wdata[2]),
        .rsp_valid(rsp_valid[2]), .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2]),
        .wr_err(wr_err[2]), .busy(busy[2])
    );

    function automatic int lat_of(input int d);
        case (d)
            0:       return 1;
            1:       return 3;
            default: return 2;
        endcase
    endfunction

    function automatic int depth_of(input int d);
        return (d == 2) ? 6 : 8;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // One write request; wr_err is checked in the cycle after accept.
    task automatic do_write(input int d, input logic [3:0] a, input logic [15:0] v,
                            input logic exp_err, input string tag);
        req_valid[d] = 1'b1;
        req_write[d] = 1'b1;
        req_addr[d]  = a;
        req_wdata[d] = v;
        tick();
        req_valid[d] = 1'b0;
        req_write[d] = 1'b0;
        check({tag, "_wr_err"}, 32'(wr_err[d]), 32'(exp_err));
    endtask

    // One isolated read: silent for RD_LAT-1 cycles, one pulse, then hold.
    task automatic do_read(input int d, input logic [3:0] a, input logic [15:0] exp_data,
                           input logic exp_err, input string tag);
        req_valid[d] = 1'b1;
        req_write[d] = 1'b0;
        req_addr[d]  = a;
        tick();
        req_valid[d] = 1'b0;
        for (int k = 1; k < lat_of(d); k++) begin
            check({tag, "_early_valid"}, 32'(rsp_valid[d]), 32'd0);
            tick();
        end
        check({tag, "_valid"}, 32'(rsp_valid[d]), 32'd1);
        check({tag, "_data"},  32'(rsp_rdata[d]), 32'(exp_data));
        check({tag, "_err"},   32'(rsp_err[d]),   32'(exp_err));
        tick();
        check({tag, "_valid_drop"}, 32'(rsp_valid[d]), 32'd0);
        check({tag, "_err_drop"},   32'(rsp_err[d]),   32'd0);
        check({tag, "_data_hold"},  32'(rsp_rdata[d]), 32'(exp_data));
    endtask

    // Call right after reset_n rises. Counts busy cycles per instance and
    // drops that instance's req_valid the moment it leaves INIT.
    task automatic run_init(input string tag);
        logic [2:0] done;
        done = 3'b000;
        for (int t = 1; t <= 50 && done != 3'b111; t++) begin
            tick();
            for (int d = 0; d < 3; d++) begin
                if (!done[d]) begin
                    if (!busy[d]) begin
                        done[d]      = 1'b1;
                        req_valid[d] = 1'b0;
                        check($sformatf("%s_init_len%0d", tag, d), 32'(t), 32'(depth_of(d)));
                        check($sformatf("%s_ready%0d", tag, d), 32'(req_ready[d]), 32'd1);
                    end else begin
                        check($sformatf("%s_ready_in_init%0d", tag, d), 32'(req_ready[d]), 32'd0);
                    end
                end
            end
        end
        check({tag, "_init_timeout"}, 32'(done), 32'b111);
        req_valid = '0;
    endtask

    initial begin
        reset_n   = 1'b0;
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        tick();
        tick();

        for (int d = 0; d < 3; d++) begin
            check($sformatf("rst_ready%0d", d), 32'(req_ready[d]), 32'd0);
            check($sformatf("rst_busy%0d", d),  32'(busy[d]),      32'd1);
            check($sformatf("rst_valid%0d", d), 32'(rsp_valid[d]), 32'd0);
            check($sformatf("rst_rdata%0d", d), 32'(rsp_rdata[d]), 32'd0);
            check($sformatf("rst_err%0d", d),   32'(rsp_err[d]),   32'd0);
            check($sformatf("rst_wr_err%0d", d), 32'(wr_err[d]),   32'd0);
        end

        // Write 0xAAAA to addr 2 held through INIT; it must be ignored.
        req_valid = 3'b111;
        req_write = 3'b111;
        for (int d = 0; d < 3; d++) begin
            req_addr[d]  = 4'd2;
            req_wdata[d] = 16'hAAAA;
        end
        reset_n = 1'b1;
        run_init("first");
        req_write = '0;

        for (int a = 0; a < 8; a++) begin
            do_read(0, 4'(a), 16'h0000, 1'b0, $sformatf("a_clear%0d", a));
        end
        do_read(1, 4'd2, 16'h0000, 1'b0, "b_ignored_init_wr");
        do_read(2, 4'd2, 16'h0000, 1'b0, "c_ignored_init_wr");

        // Instance 0: read-after-write, out-of-range via the upper bit.
        do_write(0, 4'd5, 16'hBEEF, 1'b0, "a_wr5");
        do_read(0, 4'd5, 16'hBEEF, 1'b0, "a_raw5");
        do_read(0, 4'd9, 16'h0000, 1'b1, "a_oor9");
        do_write(0, 4'd13, 16'hDEAD, 1'b1, "a_wr13");
        tick();
        check("a_wr_err_pulse_end", 32'(wr_err[0]), 32'd0);
        do_read(0, 4'd5, 16'hBEEF, 1'b0, "a_no_alias");

        // Instance 1: three back-to-back reads at RD_LAT=3.
        do_write(1, 4'd1, 16'h0011, 1'b0, "b_wr1");
        do_write(1, 4'd2, 16'h0022, 1'b0, "b_wr2");
        do_write(1, 4'd3, 16'h0033, 1'b0, "b_wr3");
        req_valid[1] = 1'b1;
        req_addr[1]  = 4'd1;
        tick();
        check("b_pipe_early1", 32'(rsp_valid[1]), 32'd0);
        req_addr[1] = 4'd2;
        tick();
        check("b_pipe_early2", 32'(rsp_valid[1]), 32'd0);
        req_addr[1] = 4'd3;
        tick();
        req_valid[1] = 1'b0;
        check("b_pipe_v1", 32'(rsp_valid[1]), 32'd1);
        check("b_pipe_d1", 32'(rsp_rdata[1]), 32'h0011);
        tick();
        check("b_pipe_v2", 32'(rsp_valid[1]), 32'd1);
        check("b_pipe_d2", 32'(rsp_rdata[1]), 32'h0022);
        tick();
        check("b_pipe_v3", 32'(rsp_valid[1]), 32'd1);
        check("b_pipe_d3", 32'(rsp_rdata[1]), 32'h0033);
        check("b_pipe_e3", 32'(rsp_err[1]),   32'd0);
        tick();
        check("b_pipe_end", 32'(rsp_valid[1]), 32'd0);
        check("b_pipe_hold", 32'(rsp_rdata[1]), 32'h0033);
        do_read(1, 4'd7, 16'h0000, 1'b0, "b_top_word");

        // Instance 2: DEPTH=6 boundaries.
        do_read(2, 4'd7, 16'h0000, 1'b1, "c_oor7");
        do_write(2, 4'd6, 16'h1234, 1'b1, "c_wr6");
        tick();
        check("c_wr_err_pulse_end", 32'(wr_err[2]), 32'd0);
        do_read(2, 4'd6, 16'h0000, 1'b1, "c_rd6");
        do_write(2, 4'd5, 16'h5555, 1'b0, "c_wr5");
        do_read(2, 4'd5, 16'h5555, 1'b0, "c_rd5");

        // Reset with a read in flight on instance 1.
        do_write(1, 4'd4, 16'h5A5A, 1'b0, "b_wr4");
        req_valid[1] = 1'b1;
        req_addr[1]  = 4'd4;
        tick();
        req_valid[1] = 1'b0;
        reset_n = 1'b0;
        #1;
        check("b_mid_rst_busy",  32'(busy[1]),      32'd1);
        check("b_mid_rst_ready", 32'(req_ready[1]), 32'd0);
        check("b_mid_rst_rdata", 32'(rsp_rdata[1]), 32'd0);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("b_flushed%0d", k), 32'(rsp_valid[1]), 32'd0);
            tick();
        end
        reset_n = 1'b1;
        run_init("second");
        do_read(1, 4'd4, 16'h0000, 1'b0, "b_rezeroed4");
        do_read(1, 4'd1, 16'h0000, 1'b0, "b_rezeroed1");
        do_read(0, 4'd5, 16'h0000, 1'b0, "a_rezeroed5");
        do_read(2, 4'd5, 16'h0000, 1'b0, "c_rezeroed5");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
